// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings for the pong match controller
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Ball gating for a state, returned as {enable, reset}
    function automatic logic [1:0] ball_ctrl(input state_t s);
        case (s)
            ST_PLAY:  ball_ctrl = 2'b10;
            ST_POINT: ball_ctrl = 2'b00;
            default:  ball_ctrl = 2'b01;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        max_int = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_sync.sv
// rtl/button_sync.sv - two-flop synchroniser with rising-edge pulse
module button_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;

    // Bring the raw pin into the clock domain and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Left combinational so the FSM acts on the third edge after the pin rises
    assign press = sync2 & ~prev;

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - two-player serve/play/point/over sequencer
module pong_match_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int AUTO_SERVE   = 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_VReset,
    input  logic               i_Miss_Left,
    input  logic               i_Miss_Right,
    input  logic               i_Serve_Btn,
    output logic               o_Ball_Enable,
    output logic               o_Ball_Reset,
    output logic               o_Serve_Dir,
    output logic [SCORE_W-1:0] o_Score_L,
    output logic [SCORE_W-1:0] o_Score_R,
    output logic [1:0]         o_Winner,
    output logic [2:0]         o_State
);

    localparam int FRAME_MAX = max_int(SERVE_FRAMES, POINT_FRAMES);
    localparam int CNT_W     = (FRAME_MAX < 1) ? 1 : $clog2(FRAME_MAX + 1);

    localparam logic [CNT_W:0]     SERVE_LIM = (CNT_W+1)'(SERVE_FRAMES);
    localparam logic [CNT_W:0]     POINT_LIM = (CNT_W+1)'(POINT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_LIM   = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             btn_press;
    logic             serve_ready;
    logic             serve_auto_done;
    logic             point_done;

    button_sync u_btn (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .btn   (i_Serve_Btn),
        .press (btn_press)
    );

    // One extra bit so the limit compare cannot overflow at the top count
    assign cnt_inc         = {1'b0, frame_cnt} + (CNT_W+1)'(1);
    assign serve_ready     = ({1'b0, frame_cnt} == SERVE_LIM);
    assign serve_auto_done = i_VReset && (cnt_inc >= SERVE_LIM);
    assign point_done      = i_VReset && (cnt_inc >= POINT_LIM);

    assign o_State = state;

    // Match sequencer; the frame counter clears on every state change
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= ST_IDLE;
            frame_cnt     <= '0;
            o_Score_L     <= '0;
            o_Score_R     <= '0;
            o_Serve_Dir   <= DIR_RIGHT;
            o_Winner      <= WIN_NONE;
            o_Ball_Enable <= 1'b0;
            o_Ball_Reset  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_press) begin
                        state                         <= ST_SERVE;
                        frame_cnt                     <= '0;
                        {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_SERVE);
                    end
                end

                ST_SERVE: begin
                    if (AUTO_SERVE != 0) begin
                        if (serve_auto_done) begin
                            state                         <= ST_PLAY;
                            frame_cnt                     <= '0;
                            {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_PLAY);
                        end else if (i_VReset) begin
                            frame_cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end else begin
                        // Presses before the hold time has elapsed are dropped
                        if (btn_press && serve_ready) begin
                            state                         <= ST_PLAY;
                            frame_cnt                     <= '0;
                            {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_PLAY);
                        end else if (i_VReset && !serve_ready) begin
                            frame_cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end
                end

                ST_PLAY: begin
                    if (i_Miss_Left && i_Miss_Right) begin
                        // Simultaneous misses are a let: reserve, nobody scores
                        state                         <= ST_SERVE;
                        frame_cnt                     <= '0;
                        {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_SERVE);
                    end else if (i_Miss_Left) begin
                        if (o_Score_R < WIN_LIM)
                            o_Score_R <= o_Score_R + SCORE_ONE;
                        o_Serve_Dir                   <= DIR_LEFT;
                        state                         <= ST_POINT;
                        frame_cnt                     <= '0;
                        {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_POINT);
                    end else if (i_Miss_Right) begin
                        if (o_Score_L < WIN_LIM)
                            o_Score_L <= o_Score_L + SCORE_ONE;
                        o_Serve_Dir                   <= DIR_RIGHT;
                        state                         <= ST_POINT;
                        frame_cnt                     <= '0;
                        {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_POINT);
                    end
                end

                ST_POINT: begin
                    if (point_done) begin
                        frame_cnt <= '0;
                        if (o_Score_L == WIN_LIM || o_Score_R == WIN_LIM) begin
                            state                         <= ST_OVER;
                            o_Winner                      <= (o_Score_L == WIN_LIM) ? WIN_LEFT : WIN_RIGHT;
                            {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_OVER);
                        end else begin
                            state                         <= ST_SERVE;
                            {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_SERVE);
                        end
                    end else if (i_VReset) begin
                        frame_cnt <= cnt_inc[CNT_W-1:0];
                    end
                end

                ST_OVER: begin
                    if (btn_press) begin
                        o_Score_L                     <= '0;
                        o_Score_R                     <= '0;
                        o_Winner                      <= WIN_NONE;
                        o_Serve_Dir                   <= DIR_RIGHT;
                        state                         <= ST_SERVE;
                        frame_cnt                     <= '0;
                        {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_SERVE);
                    end
                end

                default: begin
                    state                         <= ST_IDLE;
                    frame_cnt                     <= '0;
                    {o_Ball_Enable, o_Ball_Reset} <= ball_ctrl(ST_IDLE);
                end
            endcase
        end
    end

endmodule
